dna_reader_ctrl: RTL and testbench

DNA_READER_CTRL -- requirements
Module: dna_reader_ctrl

---
 rtl/dna_reader_ctrl_if.sv | 42 ++++
 rtl/dna_reader_ctrl.sv | 116 +++++++++++
 tb/tb_dna_reader_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dna_reader_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module   : dna_reader_ctrl_if                                              |
// | Brief    : Host request/readout and DNA_PORT pin bundle for the reader.    |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface dna_reader_ctrl_if;
    logic        start;
    logic        busy;
    logic        valid;
    logic [56:0] dna;
    logic        dna_clk;
    logic        dna_read;
    logic        dna_shift;
    logic        dna_dout;

    // master: host side plus the DNA_PORT primitive; slave: the controller
    modport master (
        output start,
        output dna_dout,
        input  busy,
        input  valid,
        input  dna,
        input  dna_clk,
        input  dna_read,
        input  dna_shift
    );

    modport slave (
        input  start,
        input  dna_dout,
        output busy,
        output valid,
        output dna,
        output dna_clk,
        output dna_read,
        output dna_shift
    );
endinterface

`default_nettype wire

// File: rtl/dna_reader_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : dna_reader_ctrl                                                 |
// | Brief    : Reads the 57-bit device DNA through DNA_PORT, MSB first.        |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module dna_reader_ctrl #(
    parameter int CLKDIV    = 32,
    parameter bit AUTOSTART = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    dna_reader_ctrl_if.slave  bus
);

    localparam int                c_DIV_W   = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX  = c_DIV_W'(CLKDIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(CLKDIV / 2);
    localparam logic [5:0]         c_LAST_CNT = 6'd56;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_LOAD  = 2'd2,
        S_SHIFT = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_DIV_W-1:0]   r_div;
    logic [5:0]           r_cnt;
    logic [56:0]          r_dna;
    logic                 r_dna_clk;
    logic                 r_dna_read;
    logic                 r_dna_shift;
    logic                 r_busy;
    logic                 r_valid;
    logic                 r_auto;

    logic [c_DIV_W-1:0]   w_div_next;
    logic                 w_tick;

    assign w_div_next = (r_div == c_DIV_MAX) ? '0 : r_div + c_DIV_W'(1);
    assign w_tick     = (r_div == '0);

    // r_auto is armed by reset so the first clock after release acts as a start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_cnt       <= '0;
            r_dna       <= '0;
            r_dna_clk   <= 1'b0;
            r_dna_read  <= 1'b0;
            r_dna_shift <= 1'b0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_auto      <= AUTOSTART;
        end else begin
            r_div     <= w_div_next;
            r_dna_clk <= (w_div_next >= c_DIV_HALF);
            r_auto    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.start || r_auto) begin
                        r_state <= S_ARM;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        r_dna   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_ARM: begin
                    if (w_tick) begin
                        r_dna_read <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // DOUT already presents bit 56 after the READ edge
                    if (w_tick) begin
                        r_dna_read  <= 1'b0;
                        r_dna_shift <= 1'b1;
                        r_dna       <= {r_dna[55:0], bus.dna_dout};
                        r_cnt       <= 6'd1;
                        r_state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        r_dna <= {r_dna[55:0], bus.dna_dout};
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == c_LAST_CNT) begin
                            r_dna_shift <= 1'b0;
                            r_busy      <= 1'b0;
                            r_valid     <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.valid     = r_valid;
    assign bus.dna       = r_dna;
    assign bus.dna_clk   = r_dna_clk;
    assign bus.dna_read  = r_dna_read;
    assign bus.dna_shift = r_dna_shift;

endmodule

`default_nettype wire

// File: tb/tb_dna_reader_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_dna_reader_ctrl                                              |
// | Brief    : Directed bench: autostart reader (CLKDIV 32), manual (CLKDIV 4).|
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_dna_reader_ctrl;

    localparam logic [56:0] c_SIM_A = 57'h0AAAAAAAAAAAAAA;
    localparam logic [56:0] c_SIM_B = 57'h1FFFFFFFFFFFFFF;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dna_reader_ctrl_if if_a ();
    dna_reader_ctrl_if if_b ();

    dna_reader_ctrl #(.CLKDIV(32), .AUTOSTART(1'b1)) u_dut_a (.clk(clk), .rst(rst_a), .bus(if_a.slave));
    dna_reader_ctrl #(.CLKDIV(4),  .AUTOSTART(1'b0)) u_dut_b (.clk(clk), .rst(rst_b), .bus(if_b.slave));

    // DNA_PORT behavioural models: load on READ, shift left on SHIFT, DOUT = MSB
    logic [56:0] sh_a = '0, sh_b = '0;
    always @(posedge if_a.dna_clk) begin
        if (if_a.dna_read)       sh_a <= c_SIM_A;
        else if (if_a.dna_shift) sh_a <= {sh_a[55:0], 1'b0};
    end
    always @(posedge if_b.dna_clk) begin
        if (if_b.dna_read)       sh_b <= c_SIM_B;
        else if (if_b.dna_shift) sh_b <= {sh_b[55:0], 1'b0};
    end
    assign if_a.dna_dout = sh_a[56];
    assign if_b.dna_dout = sh_b[56];

    int rd_edges_a = 0, sh_edges_a = 0, rd_edges_b = 0, sh_edges_b = 0;
    always @(posedge if_a.dna_clk) begin
        if (if_a.dna_read)  rd_edges_a <= rd_edges_a + 1;
        if (if_a.dna_shift) sh_edges_a <= sh_edges_a + 1;
    end
    always @(posedge if_b.dna_clk) begin
        if (if_b.dna_read)  rd_edges_b <= rd_edges_b + 1;
        if (if_b.dna_shift) sh_edges_b <= sh_edges_b + 1;
    end

    int   rd_rise_a = 0, val_rise_a = 0, n_val_a = 0, rd_len_a = 0;
    int   rd_rise_b = 0, val_rise_b = 0, n_val_b = 0;
    int   n_ovl = 0;
    logic prev_rd_a = 1'b0, prev_val_a = 1'b0, prev_rd_b = 1'b0, prev_val_b = 1'b0;
    always @(negedge clk) begin
        if (if_a.dna_read && !prev_rd_a)  rd_rise_a <= cyc;
        if (if_a.dna_read)                rd_len_a  <= rd_len_a + 1;
        if (if_a.valid && !prev_val_a) begin
            val_rise_a <= cyc;
            n_val_a    <= n_val_a + 1;
        end
        if (if_b.dna_read && !prev_rd_b)  rd_rise_b <= cyc;
        if (if_b.valid && !prev_val_b) begin
            val_rise_b <= cyc;
            n_val_b    <= n_val_b + 1;
        end
        if ((if_a.dna_read && if_a.dna_shift) || (if_b.dna_read && if_b.dna_shift))
            n_ovl <= n_ovl + 1;
        prev_rd_a  <= if_a.dna_read;
        prev_val_a <= if_a.valid;
        prev_rd_b  <= if_b.dna_read;
        prev_val_b <= if_b.valid;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid_a(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (if_a.valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_eq(tag, 64'd0, 64'd1);
        #1;
    endtask

    task automatic wait_valid_b(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (if_b.valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_eq(tag, 64'd0, 64'd1);
        #1;
    endtask

    task automatic wait_shift_edges_a(input int target, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (sh_edges_a >= target) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_eq(tag, 64'd0, 64'd1);
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        #1;
    endtask

    int b_rd, b_sh, b_nv, b_len, acc_cyc;
    logic prev_clk;

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("a_rst_ctl", {if_a.busy, if_a.valid, if_a.dna_clk, if_a.dna_read, if_a.dna_shift}, 64'd0);
        check_eq("a_rst_dna", if_a.dna, 64'd0);

        // Autostart full read
        b_rd = rd_edges_a; b_sh = sh_edges_a; b_nv = n_val_a; b_len = rd_len_a;
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        #1;
        check_eq("a_auto_busy", {if_a.busy, if_a.valid}, 64'b10);
        wait_valid_a("a_read1_timeout");
        check_eq("a_read1_dna", if_a.dna, c_SIM_A);
        check_eq("a_read1_lat", val_rise_a - (rd_rise_a - 1), 57 * 32 + 1);
        check_eq("a_read1_rd_edges", rd_edges_a - b_rd, 1);
        check_eq("a_read1_rd_len", rd_len_a - b_len, 32);
        check_eq("a_read1_sh_edges", sh_edges_a - b_sh, 56);
        check_eq("a_read1_nvalid", n_val_a - b_nv, 1);
        check_eq("a_read1_busy", if_a.busy, 1'b0);

        // Valid holds while idle
        repeat (100) @(negedge clk);
        #1;
        check_eq("a_hold", {if_a.valid, if_a.dna}, {1'b1, c_SIM_A});

        // Re-read, with a start pulse mid-shift that must be ignored
        b_rd = rd_edges_a; b_sh = sh_edges_a; b_nv = n_val_a;
        pulse_start_a();
        check_eq("a_reread_clear", {if_a.busy, if_a.valid, if_a.dna}, {2'b10, 57'd0});
        wait_shift_edges_a(b_sh + 20, "a_busy_start_timeout");
        pulse_start_a();
        wait_valid_a("a_read2_timeout");
        check_eq("a_read2_dna", if_a.dna, c_SIM_A);
        check_eq("a_read2_lat", val_rise_a - (rd_rise_a - 1), 57 * 32 + 1);
        check_eq("a_read2_rd_edges", rd_edges_a - b_rd, 1);
        check_eq("a_read2_sh_edges", sh_edges_a - b_sh, 56);
        repeat (70) @(negedge clk);
        #1;
        check_eq("a_read2_nvalid", n_val_a - b_nv, 1);
        check_eq("a_read2_idle", {if_a.busy, if_a.dna_read, if_a.dna_shift}, 64'd0);

        // Reset mid-shift: outputs clear asynchronously, then autostart re-reads
        b_sh = sh_edges_a;
        pulse_start_a();
        wait_shift_edges_a(b_sh + 30, "a_midrst_timeout");
        @(negedge clk);
        #2;
        rst_a = 1'b1;
        #1;
        check_eq("a_async_rst_ctl", {if_a.busy, if_a.valid, if_a.dna_clk, if_a.dna_read, if_a.dna_shift}, 64'd0);
        check_eq("a_async_rst_dna", if_a.dna, 64'd0);
        b_rd = rd_edges_a; b_sh = sh_edges_a; b_nv = n_val_a;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        wait_valid_a("a_read3_timeout");
        check_eq("a_read3_dna", if_a.dna, c_SIM_A);
        check_eq("a_read3_nvalid", n_val_a - b_nv, 1);
        check_eq("a_read3_sh_edges", sh_edges_a - b_sh, 56);
        check_eq("a_read3_lat", val_rise_a - (rd_rise_a - 1), 57 * 32 + 1);

        // Manual-start instance: nothing happens until start
        @(negedge clk);
        rst_b = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check_eq("b_no_auto", {if_b.busy, if_b.valid, if_b.dna_read, if_b.dna_shift}, 64'd0);
        check_eq("b_no_edges", rd_edges_b + sh_edges_b, 64'd0);

        // Find a tick: the cycle where dna_clk has just fallen has div == 0
        prev_clk = if_b.dna_clk;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (prev_clk && !if_b.dna_clk) break;
            prev_clk = if_b.dna_clk;
        end
        if_b.start = 1'b1;
        @(negedge clk);
        if_b.start = 1'b0;
        acc_cyc = cyc;
        #1;
        check_eq("b_accept", {if_b.busy, if_b.valid}, 64'b10);
        wait_valid_b("b_read_timeout");
        check_eq("b_arm_delay", rd_rise_b - acc_cyc, 4);
        check_eq("b_dna", if_b.dna, c_SIM_B);
        check_eq("b_lat", val_rise_b - (rd_rise_b - 1), 57 * 4 + 1);
        check_eq("b_rd_edges", rd_edges_b, 1);
        check_eq("b_sh_edges", sh_edges_b, 56);
        check_eq("b_nvalid", n_val_b, 1);

        check_eq("rd_sh_overlap", n_ovl, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
